// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the core's fetch/load-store requesters, the arbiter and
// the shared 64-bit synchronous memory port.
//   slave  : arbiter side (takes requests and read data, drives grants,
//            responses, the memory address/write strobe/write data and busy)
//   master : environment side (drives requests and memory read data)
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 64
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_valid;
    logic [31:0]       i_rdata;

    logic              d_req;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [63:0]       d_wdata;
    logic              d_gnt;
    logic              d_valid;
    logic [63:0]       d_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr;
    logic [63:0]       mem_wdata;
    logic [63:0]       mem_rdata;

    logic              busy;

    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
        output i_gnt, i_valid, i_rdata, d_gnt, d_valid, d_rdata,
               mem_addr, mem_wr, mem_wdata, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
        input  i_gnt, i_valid, i_rdata, d_gnt, d_valid, d_rdata,
               mem_addr, mem_wr, mem_wdata, busy
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency 64-bit memory port between
// instruction fetch and data load/store. One access is in flight at a time:
// IDLE (arbitrate, combinational grant) -> ACCESS (MEM_LAT cycles) ->
// RESP (one-cycle valid pulse) -> IDLE.
// Ports:
//   Clk   : rising-edge clock
//   Reset : asynchronous active-high reset
//   bus   : unified_mem_arbiter_if.slave -- fetch request/response,
//           data request/response, memory port and busy flag
module unified_mem_arbiter #(
    parameter int MEM_LAT = 2,
    parameter int ADDR_W  = 64
) (
    input  logic                  Clk,
    input  logic                  Reset,
    unified_mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic SEL_INSTR = 1'b0;
    localparam logic SEL_DATA  = 1'b1;

    state_t            state_r;
    logic [3:0]        cnt_r;
    logic              last_r;
    logic              sel_r;
    logic [ADDR_W-1:0] addr_r;
    logic              wr_r;
    logic [63:0]       wdata_r;
    logic              mem_wr_r;
    logic              busy_r;
    logic              i_valid_r;
    logic              d_valid_r;
    logic [31:0]       i_rdata_r;
    logic [63:0]       d_rdata_r;
    logic              i_win_s;
    logic              d_win_s;

    // Winner selection in IDLE: a lone requester wins, a tie goes opposite to last
    always_comb begin
        i_win_s = 1'b0;
        d_win_s = 1'b0;
        if (state_r == ST_IDLE) begin
            if (bus.i_req && bus.d_req) begin
                if (last_r == SEL_DATA) begin
                    i_win_s = 1'b1;
                end else begin
                    d_win_s = 1'b1;
                end
            end else if (bus.i_req) begin
                i_win_s = 1'b1;
            end else if (bus.d_req) begin
                d_win_s = 1'b1;
            end else begin
                i_win_s = 1'b0;
                d_win_s = 1'b0;
            end
        end else begin
            i_win_s = 1'b0;
            d_win_s = 1'b0;
        end
    end

    // Access sequencer: latch winner, count out memory latency, pulse valid
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            last_r    <= SEL_INSTR;
            sel_r     <= SEL_INSTR;
            addr_r    <= '0;
            wr_r      <= 1'b0;
            wdata_r   <= 64'd0;
            mem_wr_r  <= 1'b0;
            busy_r    <= 1'b0;
            i_valid_r <= 1'b0;
            d_valid_r <= 1'b0;
            i_rdata_r <= 32'd0;
            d_rdata_r <= 64'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_win_s || d_win_s) begin
                        sel_r    <= d_win_s;
                        last_r   <= d_win_s;
                        addr_r   <= d_win_s ? bus.d_addr : bus.i_addr;
                        wr_r     <= d_win_s & bus.d_wr;
                        wdata_r  <= d_win_s ? bus.d_wdata : 64'd0;
                        cnt_r    <= 4'(MEM_LAT - 1);
                        // Write strobe is live only for the first ACCESS cycle
                        mem_wr_r <= d_win_s & bus.d_wr;
                        busy_r   <= 1'b1;
                        state_r  <= ST_ACCESS;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    mem_wr_r <= 1'b0;
                    if (cnt_r == 4'd0) begin
                        if (sel_r == SEL_INSTR) begin
                            // Pick the 32-bit instruction half by address bit 2
                            i_rdata_r <= addr_r[2] ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
                        end else if (!wr_r) begin
                            d_rdata_r <= bus.mem_rdata;
                        end else begin
                            d_rdata_r <= d_rdata_r;
                        end
                        i_valid_r <= (sel_r == SEL_INSTR);
                        d_valid_r <= (sel_r == SEL_DATA);
                        state_r   <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    i_valid_r <= 1'b0;
                    d_valid_r <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    mem_wr_r  <= 1'b0;
                    busy_r    <= 1'b0;
                    i_valid_r <= 1'b0;
                    d_valid_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.i_gnt     = i_win_s;
    assign bus.d_gnt     = d_win_s;
    assign bus.i_valid   = i_valid_r;
    assign bus.d_valid   = d_valid_r;
    assign bus.i_rdata   = i_rdata_r;
    assign bus.d_rdata   = d_rdata_r;
    assign bus.mem_addr  = addr_r;
    assign bus.mem_wr    = mem_wr_r;
    assign bus.mem_wdata = wdata_r;
    assign bus.busy      = busy_r;
endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Shares a single synchronous 64-bit memory port between the instruction-fetch requester and the data load/store requester of the multicycle RISC-V core. It arbitrates round-robin, latches the winning request, and sequences the fixed-latency memory access. It returns read data or a write acknowledge with a one-cycle valid pulse. It sits between the control unit/PC/B-register side and the memory array, and replaces the separate instruction and data memory paths.

Parameters:
MEM_LAT, 2, memory read latency in cycles (addr presented to memRdata valid); legal range 1..15
ADDR_W, 64, address width

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
i_req  in  1  instruction fetch request; held high until i_gnt
i_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored
i_gnt  out  1  fetch request accepted this cycle
i_valid  out  1  one-cycle pulse; i_rdata valid
i_rdata  out  32  fetched instruction
d_req  in  1  data request; held high until d_gnt
d_wr  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data byte address; bits [2:0] ignored
d_wdata  in  64  store data
d_gnt  out  1  data request accepted this cycle
d_valid  out  1  one-cycle pulse; load data valid or store done
d_rdata  out  64  load data
mem_addr  out  ADDR_W  address to memory
mem_wr  out  1  memory write strobe
mem_wdata  out  64  memory write data
mem_rdata  in  64  memory read data, MEM_LAT cycles after mem_addr
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, immediate): state IDLE, cnt=0, last=INSTR, all outputs 0 including mem_wr and mem_addr; i_rdata/d_rdata=0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: winner is computed combinationally from i_req/d_req.
  - Single requester wins.
  - Both requesting: grant the side opposite to `last` (first tie after reset goes to data).
  - Winner's gnt is high combinationally in this cycle.
  - At the clock edge: latch sel, addr, wr (0 for instruction), wdata; update last=sel; cnt=MEM_LAT-1; go to ACCESS.
  - No request: stay in IDLE; gnt low.
- ACCESS: mem_addr = latched addr, mem_wdata = latched wdata.
  - mem_wr=1 only in the first ACCESS cycle and only for a latched store.
  - cnt decrements each cycle.
  - When cnt==0: on the edge, capture mem_rdata into i_rdata (instr: addr[2]=0 -> [31:0], 1 -> [63:32]) or d_rdata (loads only; stores leave d_rdata unchanged). Go to RESP.
- RESP: i_valid or d_valid = 1 for exactly this cycle, selected by latched sel. Next state is IDLE.
- Latency: valid asserts MEM_LAT+1 cycles after the gnt cycle. Min period between grants = MEM_LAT+2 cycles.
- Requests arriving while not in IDLE are ignored; the requester keeps req high. gnt is never asserted outside IDLE. Input changes after gnt have no effect on the access in flight.
- A requester keeping req high after valid is re-arbitrated in the next IDLE cycle. With both held high, grants strictly alternate.
- Outputs i_rdata/d_rdata hold until the next capture for that side.
- mem_addr holds its last latched value in IDLE/RESP. mem_wr is 0 outside the first ACCESS cycle.
- Reset mid-ACCESS or mid-RESP: access aborted, no valid pulse, mem_wr drops immediately, last returns to INSTR.
- i_gnt and d_gnt are never high together. i_valid and d_valid are never high together.

Test Plan:
1. MEM_LAT=2, only i_req=1, i_addr=0x4, mem word 0 = 0x00A00093_00000013 -> i_gnt in cycle 0; i_valid in cycle 3; i_rdata=0x00A00093.
2. d_req=1, d_wr=1, d_addr=0x10, d_wdata=0xDEADBEEF_CAFEF00D -> mem_wr high for exactly 1 cycle with mem_addr=0x10; d_valid at cycle 3; d_rdata unchanged. A later load from 0x10 returns 0xDEADBEEF_CAFEF00D.
3. After reset, i_req and d_req rise together and are both held -> grant order D, I, D, I; consecutive gnt pulses spaced 4 cycles (MEM_LAT=2).
4. i_req held high for 3 fetches at 0x0, 0x4, 0x8 -> three i_valid pulses at cycles 3, 7, 11; busy low only in cycles 0, 4, 8.
5. Store granted, Reset asserted in the 1st ACCESS cycle -> mem_wr, busy, and all valids fall without a clock edge. After release, an idle cycle shows no pending valid, and the next tie goes to data.
6. MEM_LAT=1 build, load at d_addr=0x18 -> d_valid 2 cycles after d_gnt. d_req stays asserted and i_req rises during ACCESS -> i_gnt in the next IDLE cycle.
